// File: rtl/count_scheduler_if.sv
// -----------------------------------------------------------------------------
// count_scheduler_if
// Purpose : Bundles the two-requester handshake and the shared-counter status
//           of count_scheduler into one interface.
// Signals :
//   req0/req1   requester asks for a counting run (held until its gnt is seen)
//   len0/len1   terminal count for that requester, sampled in the grant cycle
//   gnt0/gnt1   requester owns the counter (RUN and DONE)
//   busy        scheduler is not idle
//   counter     shared up-counter value
//   done        one-cycle pulse on run completion
//   done_id     owner index of the completed run (held between pulses)
// Modports:
//   master  requester side (drives req/len, observes the rest)
//   slave   scheduler side (observes req/len, drives the rest)
// -----------------------------------------------------------------------------
interface count_scheduler_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] len0;
    logic             req1;
    logic [WIDTH-1:0] len1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic [WIDTH-1:0] counter;
    logic             done;
    logic             done_id;

    modport master (
        output req0, len0, req1, len1,
        input  gnt0, gnt1, busy, counter, done, done_id
    );

    modport slave (
        input  req0, len0, req1, len1,
        output gnt0, gnt1, busy, counter, done, done_id
    );
endinterface

// File: rtl/count_scheduler.sv
// -----------------------------------------------------------------------------
// count_scheduler
// Purpose : Arbitrates a single shared up-counter between two requesters.
//           A granted requester gets one run in which the counter steps
//           0..len; completion is flagged by a one-cycle done pulse carrying
//           the owner index. At least one idle cycle separates runs.
// Ports   :
//   clk    single clock, all state updates on its rising edge
//   rst_n  synchronous active-low reset
//   bus    count_scheduler_if.slave (req/len in, gnt/busy/counter/done out)
// Config  :
//   ROUND_ROBIN_EN  when defined, simultaneous requests alternate using a
//                   last_served flag; otherwise requester 0 has fixed priority.
// -----------------------------------------------------------------------------
module count_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    count_scheduler_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] counter_q;
    logic [WIDTH-1:0] target_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             busy_q;
    logic             done_q;
    logic             done_id_q;

    // Arbitration result for the current IDLE cycle.
    logic             owner_d;
    logic [WIDTH-1:0] target_d;

`ifdef ROUND_ROBIN_EN
    // Index of the requester that received the most recent grant.
    logic             last_served_q;
`endif

    always_comb begin
        owner_d  = 1'b0;
`ifdef ROUND_ROBIN_EN
        if (bus.req0 && bus.req1) begin
            owner_d = ~last_served_q;
        end else begin
            owner_d = bus.req1;
        end
`else
        // Requester 0 wins whenever it asks.
        owner_d = ~bus.req0;
`endif
        target_d = owner_d ? bus.len1 : bus.len0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            counter_q     <= '0;
            target_q      <= '0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            done_id_q     <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_served_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.req0 || bus.req1) begin
                        state_q       <= RUN;
                        target_q      <= target_d;
                        counter_q     <= '0;
                        gnt0_q        <= ~owner_d;
                        gnt1_q        <= owner_d;
                        busy_q        <= 1'b1;
`ifdef ROUND_ROBIN_EN
                        last_served_q <= owner_d;
`endif
                    end
                end

                RUN: begin
                    // The compare happens before the increment, so the
                    // counter stops at target and can never wrap.
                    if (counter_q == target_q) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        done_id_q <= gnt1_q;
                    end else begin
                        counter_q <= counter_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end

                DONE: begin
                    // No grant from here: the next run always starts in IDLE.
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.busy    = busy_q;
    assign bus.counter = counter_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;

endmodule

// File: doc/count_scheduler.md
COUNT_SCHEDULER -- requirements
Module: count_scheduler

Interface
REQ-001 Parameter WIDTH, default 8, counter and run-length width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0  input  1  requester 0 asks for a counting run; held high until gnt0 is seen.
REQ-005 len0  input  WIDTH  requester 0 terminal count; sampled only in the grant cycle.
REQ-006 req1  input  1  requester 1 asks for a counting run; held high until gnt1 is seen.
REQ-007 len1  input  WIDTH  requester 1 terminal count; sampled only in the grant cycle.
REQ-008 gnt0  output  1  requester 0 owns the counter (RUN and DONE states).
REQ-009 gnt1  output  1  requester 1 owns the counter (RUN and DONE states).
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 counter  output  WIDTH  shared up-counter value.
REQ-012 done  output  1  one-cycle pulse on run completion.
REQ-013 done_id  output  1  owner index of the completed run; valid when done=1, holds otherwise.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; all outputs are registered.
REQ-015 IDLE: if req0 or req1 is high, the next edge SHALL select an owner, latch target=len of owner, clear counter to 0, assert owner gnt and enter RUN.
REQ-016 IDLE with no request: state, counter, gnt0/gnt1 and done SHALL stay unchanged or low; counter holds its last value.
REQ-017 RUN: if counter==target, next edge SHALL enter DONE with counter held; otherwise counter SHALL increment by 1.
REQ-018 A run SHALL therefore occupy target+1 RUN cycles, with counter values 0..target.
REQ-019 counter SHALL never exceed target and SHALL never wrap; len=2^WIDTH-1 ends at all-ones.
REQ-020 len=0 SHALL give exactly one RUN cycle with counter=0, then DONE.
REQ-021 DONE: done=1 and done_id=owner for exactly one cycle; gnt is still high; the next edge SHALL enter IDLE and drop gnt.
REQ-022 No grant SHALL be issued from DONE; at least one IDLE cycle separates consecutive runs.
REQ-023 Requests and len changes during RUN or DONE SHALL be ignored, including the owner dropping its req.
REQ-024 gnt0 and gnt1 SHALL never be high simultaneously.

Reset
REQ-025 On a rising edge with rst_n=0: state=IDLE, counter=0, gnt0=gnt1=0, busy=0, done=0, done_id=0, target=0, last_served=1.
REQ-026 Reset SHALL take effect only at a clock edge; a mid-cycle rst_n pulse that does not span an edge SHALL have no effect.
REQ-027 Reset during RUN or DONE SHALL abort the run with no done pulse.
REQ-028 Reset SHALL override all requests in the same cycle.

Configuration
REQ-029 With macro ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester that is not last_served; last_served updates on every grant.
REQ-030 Without ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to req0 (fixed priority), and last_served is not implemented.
REQ-031 A single request SHALL be granted in both configurations.

Verification
REQ-032 rst_n=0 for 2 edges, then released at a non-edge time -> counter=0, gnt0=gnt1=busy=done=0 until the first request.
REQ-033 req0=1, len0=3 -> gnt0 rises at the next edge; counter 0,1,2,3 over 4 cycles; done=1, done_id=0 for 1 cycle; gnt0 falls the cycle after done.
REQ-034 req0=req1=1 held, len0=len1=2, ROUND_ROBIN_EN -> runs alternate 0,1,0; without the macro -> requester 0 is granted every run.
REQ-035 req1=1, len1=0 -> one RUN cycle with counter=0, then done with done_id=1.
REQ-036 rst_n=0 at the edge where counter=5 during a len=9 run -> next state IDLE, counter=0, gnt low, no done pulse.
REQ-037 len0=255 (WIDTH=8) -> counter reaches 255 with no wrap, done asserted, 256 RUN cycles.
